// File: rtl/armleocpu_ptw_pkg.sv
// Shared definitions for the Sv32 page-table walker: PTE bit positions,
// memory response codes and the PTE decode result type.
package armleocpu_ptw_pkg;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_G = 5;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_PAGE,
    FAULT_ACCESS
  } fault_e;

  typedef struct packed {
    fault_e      fault;
    logic        leaf;
    logic [21:0] next_ppn;
  } pte_result_t;

endpackage

// File: rtl/armleocpu_ptw_pte_decode.sv
// Combinational classification of one PTE read: fault kind, leaf flag and
// the PPN to use next (table pointer for non-leaf, final PPN for leaf).
module armleocpu_ptw_pte_decode
  import armleocpu_ptw_pkg::*;
(
  input  logic [31:0]  pte,
  input  logic [1:0]   response,
  input  logic         level,
  input  logic [9:0]   vpn0,
  output pte_result_t  result
);

  logic is_leaf;

  always_comb begin
    is_leaf         = pte[PTE_R] | pte[PTE_X];
    result.fault    = FAULT_NONE;
    result.leaf     = is_leaf;
    result.next_ppn = pte[31:10];
    if (response != RESP_OKAY) begin
      result.fault = FAULT_ACCESS;
    end else if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
      result.fault = FAULT_PAGE;
    end else if (is_leaf) begin
      // Megapage: low PPN bits must be zero; vpn0 fills them in.
      if (level) begin
        if (pte[19:10] != '0) result.fault = FAULT_PAGE;
        else                  result.next_ppn = {pte[31:20], vpn0};
      end
    end else if (!level) begin
      result.fault = FAULT_PAGE;
    end
  end

endmodule

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: up to two sequential PTE reads translating a VPN
// into a PPN plus leaf metadata, with structural fault detection.
module armleocpu_ptw
  import armleocpu_ptw_pkg::*;
#(
  parameter int unsigned PHYS_W = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resolve_request,
  output logic              resolve_ack,
  input  logic [19:0]       resolve_virtual_address,
  input  logic [21:0]       satp_ppn,
  output logic              resolve_done,
  output logic              resolve_pagefault,
  output logic              resolve_accessfault,
  output logic [21:0]       resolve_physical_address,
  output logic [7:0]        resolve_metadata,
  output logic              m_transaction,
  output logic [PHYS_W-1:0] m_address,
  input  logic              m_transaction_done,
  input  logic [1:0]        m_transaction_response,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_REQ,
    STATE_DONE
  } state_e;

  state_e      state, state_nxt;
  logic [19:0] vpn;
  logic [21:0] table_ppn;
  logic        level;
  logic [9:0]  vpn_level;
  logic        transfer;
  logic        walk_end;
  pte_result_t pte_res;

  armleocpu_ptw_pte_decode u_pte_decode (
    .pte      (m_rdata),
    .response (m_transaction_response),
    .level    (level),
    .vpn0     (vpn[9:0]),
    .result   (pte_res)
  );

  assign vpn_level = level ? vpn[19:10] : vpn[9:0];
  assign transfer  = resolve_request && resolve_ack;
  // Only a clean non-leaf at level 1 continues the walk.
  assign walk_end  = m_transaction_done &&
                     !((pte_res.fault == FAULT_NONE) && !pte_res.leaf && level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STATE_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STATE_IDLE: if (transfer) state_nxt = STATE_REQ;
      STATE_REQ:  if (walk_end) state_nxt = STATE_DONE;
      STATE_DONE: state_nxt = STATE_IDLE;
      default:    state_nxt = STATE_IDLE;
    endcase
  end

  always_comb begin
    resolve_ack   = 1'b0;
    resolve_done  = 1'b0;
    m_transaction = 1'b0;
    m_address     = '0;
    case (state)
      STATE_IDLE: resolve_ack = 1'b1;
      STATE_REQ: begin
        m_transaction = 1'b1;
        m_address     = {table_ppn, vpn_level, 2'b00};
      end
      STATE_DONE: resolve_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpn                      <= '0;
      table_ppn                <= '0;
      level                    <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_metadata         <= '0;
    end else if (transfer) begin
      vpn                 <= resolve_virtual_address;
      table_ppn           <= satp_ppn;
      level               <= 1'b1;
      resolve_pagefault   <= 1'b0;
      resolve_accessfault <= 1'b0;
    end else if ((state == STATE_REQ) && m_transaction_done) begin
      resolve_metadata    <= m_rdata[7:0];
      resolve_pagefault   <= (pte_res.fault == FAULT_PAGE);
      resolve_accessfault <= (pte_res.fault == FAULT_ACCESS);
      if (walk_end) begin
        resolve_physical_address <= pte_res.next_ppn;
      end else begin
        table_ppn <= pte_res.next_ppn;
        level     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Scoreboard bench for armleocpu_ptw: a behavioural PTE memory answers reads,
// expected addresses and results are queued per walk and checked on output.
module tb_armleocpu_ptw;

  localparam int unsigned PHYS_W = 34;
  localparam logic [1:0]  OK  = 2'b00;
  localparam logic [1:0]  ERR = 2'b10;
  localparam logic [19:0] VPN  = 20'h00402;
  localparam logic [21:0] SATP = 22'h00001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              resolve_request;
  logic              resolve_ack;
  logic [19:0]       resolve_virtual_address;
  logic [21:0]       satp_ppn;
  logic              resolve_done;
  logic              resolve_pagefault;
  logic              resolve_accessfault;
  logic [21:0]       resolve_physical_address;
  logic [7:0]        resolve_metadata;
  logic              m_transaction;
  logic [PHYS_W-1:0] m_address;
  logic              m_transaction_done;
  logic [1:0]        m_transaction_response;
  logic [31:0]       m_rdata;

  armleocpu_ptw #(.PHYS_W(PHYS_W)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .resolve_request          (resolve_request),
    .resolve_ack              (resolve_ack),
    .resolve_virtual_address  (resolve_virtual_address),
    .satp_ppn                 (satp_ppn),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_metadata         (resolve_metadata),
    .m_transaction            (m_transaction),
    .m_address                (m_address),
    .m_transaction_done       (m_transaction_done),
    .m_transaction_response   (m_transaction_response),
    .m_rdata                  (m_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned xfer_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && resolve_request && resolve_ack) xfer_cyc <= cyc;
  end

  typedef struct {
    logic        pf;
    logic        af;
    logic [21:0] ppn;
    logic [7:0]  meta;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  logic [33:0] exp_addr[$];
  logic [33:0] mem_a[2];
  logic [31:0] mem_d[2];
  logic [1:0]  mem_r[2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [33:0] lookup(input logic [33:0] addr);
    for (int i = 0; i < 2; i++)
      if (mem_a[i] == addr) return {mem_r[i], mem_d[i]};
    return {OK, 32'h0};
  endfunction

  task automatic set_mem(input logic [33:0] a0, input logic [31:0] d0, input logic [1:0] r0,
                         input logic [33:0] a1, input logic [31:0] d1, input logic [1:0] r1);
    mem_a[0] = a0; mem_d[0] = d0; mem_r[0] = r0;
    mem_a[1] = a1; mem_d[1] = d1; mem_r[1] = r1;
  endtask

  task automatic expect_walk(input logic pf, input logic af, input logic [21:0] ppn,
                             input logic [7:0] meta, input int unsigned lat);
    exp_t e;
    e.pf = pf; e.af = af; e.ppn = ppn; e.meta = meta; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic do_walk(input logic [19:0] vpn, input logic [21:0] satp,
                         input int unsigned delay, input bit toggle, input bit reset_l0);
    int unsigned wait_cnt = 0;
    int unsigned reads = 0;
    logic [33:0] cur_addr = '0;
    bit          finished = 0;
    bit          have_e = 0;
    exp_t        e;
    @(negedge clk);
    check("ack_idle", resolve_ack, 1);
    resolve_request = 1'b1;
    resolve_virtual_address = vpn;
    satp_ppn = satp;
    @(negedge clk);
    resolve_request = 1'b0;
    check("faults_cleared", {resolve_pagefault, resolve_accessfault}, 0);
    check("ack_busy", resolve_ack, 0);
    for (int unsigned t = 0; t < 80 && !finished; t++) begin
      if (resolve_done) begin
        finished = 1;
        resolve_request = 1'b0;
        m_transaction_done = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          have_e = 1;
          check("pagefault", resolve_pagefault, e.pf);
          check("accessfault", resolve_accessfault, e.af);
          if (!e.pf && !e.af) begin
            check("ppn", resolve_physical_address, e.ppn);
            check("metadata", resolve_metadata, e.meta);
          end
          if (e.lat != 0) check("latency", cyc - xfer_cyc, e.lat);
        end
        check("reads_missing", exp_addr.size(), 0);
        @(negedge clk);
        check("done_pulse", resolve_done, 0);
        check("ack_back", resolve_ack, 1);
        check("mtx_idle", m_transaction, 0);
        if (have_e && !e.pf && !e.af) check("ppn_hold", resolve_physical_address, e.ppn);
      end else begin
        if (m_transaction) begin
          if (wait_cnt == 0) begin
            cur_addr = m_address;
            if (exp_addr.size() == 0) check("extra_read", 1, 0);
            else check("m_address", m_address, exp_addr.pop_front());
            if (reset_l0 && reads == 1) begin
              m_transaction_done = 1'b0;
              rst_n = 1'b0;
              #1;
              check("rst_drops_mtx", m_transaction, 0);
              check("rst_no_done", resolve_done, 0);
              check("rst_ppn", resolve_physical_address, 0);
              for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("rst_hold_no_done", resolve_done, 0);
              end
              rst_n = 1'b1;
              #1;
              check("rst_ack", resolve_ack, 1);
              return;
            end
          end else begin
            check("addr_stable", m_address, cur_addr);
          end
          if (wait_cnt == delay) begin
            {m_transaction_response, m_rdata} = lookup(m_address);
            m_transaction_done = 1'b1;
            wait_cnt = 0;
            reads++;
          end else begin
            m_transaction_done = 1'b0;
            wait_cnt++;
          end
        end else begin
          m_transaction_done = 1'b0;
        end
        if (toggle) begin
          resolve_request = ~resolve_request;
          satp_ppn = 22'($urandom);
          resolve_virtual_address = 20'($urandom);
        end
        @(negedge clk);
      end
    end
    if (!finished) check("walk_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    resolve_request = 1'b0;
    resolve_virtual_address = '0;
    satp_ppn = '0;
    m_transaction_done = 1'b0;
    m_transaction_response = OK;
    m_rdata = '0;
    #1;
    check("reset_ack", resolve_ack, 1);
    check("reset_mtx", m_transaction, 0);
    check("reset_maddr", m_address, 0);
    check("reset_done", resolve_done, 0);
    check("reset_faults", {resolve_pagefault, resolve_accessfault}, 0);
    check("reset_ppn", resolve_physical_address, 0);
    check("reset_meta", resolve_metadata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 4 KiB page
    set_mem(34'h1004, 32'h00000801, OK, 34'h2008, 32'h000D14CF, OK);
    exp_addr.push_back(34'h1004); exp_addr.push_back(34'h2008);
    expect_walk(0, 0, 22'h00345, 8'hCF, 3);
    do_walk(VPN, SATP, 0, 0, 0);

    // Megapage
    set_mem(34'h1004, 32'h005000CF, OK, 34'h0, 32'h0, OK);
    exp_addr.push_back(34'h1004);
    expect_walk(0, 0, 22'h01402, 8'hCF, 2);
    do_walk(VPN, SATP, 0, 0, 0);

    // Level-1 page faults: misaligned megapage, invalid, W-only
    set_mem(34'h1004, 32'h005004CF, OK, 34'h0, 32'h0, OK);
    exp_addr.push_back(34'h1004);
    expect_walk(1, 0, 22'h0, 8'h0, 2);
    do_walk(VPN, SATP, 0, 0, 0);

    set_mem(34'h1004, 32'h00000000, OK, 34'h0, 32'h0, OK);
    exp_addr.push_back(34'h1004);
    expect_walk(1, 0, 22'h0, 8'h0, 2);
    do_walk(VPN, SATP, 0, 0, 0);

    set_mem(34'h1004, 32'h00000005, OK, 34'h0, 32'h0, OK);
    exp_addr.push_back(34'h1004);
    expect_walk(1, 0, 22'h0, 8'h0, 2);
    do_walk(VPN, SATP, 0, 0, 0);

    // Non-leaf at level 0
    set_mem(34'h1004, 32'h00000801, OK, 34'h2008, 32'h00000801, OK);
    exp_addr.push_back(34'h1004); exp_addr.push_back(34'h2008);
    expect_walk(1, 0, 22'h0, 8'h0, 3);
    do_walk(VPN, SATP, 0, 0, 0);

    // Access faults at level 1 and level 0
    set_mem(34'h1004, 32'h00000801, ERR, 34'h2008, 32'h000D14CF, OK);
    exp_addr.push_back(34'h1004);
    expect_walk(0, 1, 22'h0, 8'h0, 2);
    do_walk(VPN, SATP, 0, 0, 0);

    set_mem(34'h1004, 32'h00000801, OK, 34'h2008, 32'h000D14CF, ERR);
    exp_addr.push_back(34'h1004); exp_addr.push_back(34'h2008);
    expect_walk(0, 1, 22'h0, 8'h0, 3);
    do_walk(VPN, SATP, 0, 0, 0);

    // Backpressure with noisy request/satp/VPN mid-walk
    set_mem(34'h1004, 32'h00000801, OK, 34'h2008, 32'h000D14CF, OK);
    exp_addr.push_back(34'h1004); exp_addr.push_back(34'h2008);
    expect_walk(0, 0, 22'h00345, 8'hCF, 13);
    do_walk(VPN, SATP, 5, 1, 0);

    // Reset during the level-0 read
    set_mem(34'h1004, 32'h00000801, OK, 34'h2008, 32'h000D14CF, OK);
    exp_addr.push_back(34'h1004); exp_addr.push_back(34'h2008);
    do_walk(VPN, SATP, 1, 0, 1);

    // Fresh walk after reset, different VPN/satp and leaf metadata
    set_mem(34'h2A00C, {22'h00123, 10'h001}, OK, 34'h123FFC, {22'h3ABCD, 10'h00B}, OK);
    exp_addr.push_back(34'h2A00C); exp_addr.push_back(34'h123FFC);
    expect_walk(0, 0, 22'h3ABCD, 8'h0B, 3);
    do_walk({10'd3, 10'h3FF}, 22'h0002A, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("addr_drained", exp_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
